// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the integer pipeline.
//
// Computes the ALU result of the instruction from decode and registers it,
// together with the store data and writeback controls, for the memory stage.
// Single-cycle ops have one cycle of latency. MUL is optional:
//   EX_MUL_EN defined   : MUL runs on a multi-cycle shift-add multiplier
//                         (IDLE/BUSY FSM); stall_o holds upstream meanwhile.
//   EX_MUL_EN undefined : no multiplier; a valid MUL completes in one cycle
//                         with result 0, writeback disabled and an
//                         illegal_op_o pulse. stall_o is tied 0.
//
// Ports
//   clk_i, rst_i        rising-edge clock, asynchronous active-low reset
//   flush_i             squash in-flight and incoming instruction
//   valid_i, alu_op_i   instruction present, op (0 ADD .. 6 SLL, 7 MUL)
//   use_imm_i           operand2 = imm_i instead of reg_a_data_i
//   reg_a/b_data_i      register operands (operand1 = reg_b_data_i)
//   imm_i, wr_reg_i     immediate, destination register index
//   is_load/store_i     memory op flags, reg_wr_en_i writeback enable
//   stall_o             upstream must hold its inputs while high
//   mem_*_o             registered results for the memory stage
//   illegal_op_o        registered one-cycle pulse on an unsupported MUL
module ex_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REGISTER_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [2:0]                alu_op_i,
  input  logic                      use_imm_i,
  input  logic [DATA_WIDTH-1:0]     reg_a_data_i,
  input  logic [DATA_WIDTH-1:0]     reg_b_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
  input  logic                      is_load_i,
  input  logic                      is_store_i,
  input  logic                      reg_wr_en_i,
  output logic                      stall_o,
  output logic                      mem_valid_o,
  output logic                      mem_is_load_o,
  output logic                      mem_is_store_o,
  output logic                      mem_reg_wr_en_o,
  output logic [DATA_WIDTH-1:0]     mem_alu_result_o,
  output logic [DATA_WIDTH-1:0]     mem_reg_a_data_o,
  output logic [REGISTER_WIDTH-1:0] mem_wr_reg_o,
  output logic                      illegal_op_o
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_MUL = 3'd7
  } alu_op_e;

  logic [DATA_WIDTH-1:0] op1, op2, alu_res;
  logic                  is_mul;

  assign op1    = reg_b_data_i;
  assign op2    = use_imm_i ? imm_i : reg_a_data_i;
  assign is_mul = valid_i && (alu_op_e'(alu_op_i) == OP_MUL);

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(alu_op_i))
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLL:  alu_res = op1 << op2[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  logic                      mem_valid_q, mem_valid_d;
  logic                      mem_is_load_q, mem_is_load_d;
  logic                      mem_is_store_q, mem_is_store_d;
  logic                      mem_reg_wr_en_q, mem_reg_wr_en_d;
  logic [DATA_WIDTH-1:0]     mem_alu_result_q, mem_alu_result_d;
  logic [DATA_WIDTH-1:0]     mem_reg_a_data_q, mem_reg_a_data_d;
  logic [REGISTER_WIDTH-1:0] mem_wr_reg_q, mem_wr_reg_d;

`ifdef EX_MUL_EN
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(DATA_WIDTH - 1);

  state_e                    state_q, state_d;
  logic [SHW-1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [REGISTER_WIDTH-1:0] mul_wr_reg_q, mul_wr_reg_d;
  logic                      mul_wr_en_q, mul_wr_en_d;
  logic [DATA_WIDTH-1:0]     mul_sum;
  logic                      stall;

  always_comb begin
    mem_valid_d      = 1'b0;
    mem_is_load_d    = mem_is_load_q;
    mem_is_store_d   = mem_is_store_q;
    mem_reg_wr_en_d  = mem_reg_wr_en_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_reg_a_data_d = mem_reg_a_data_q;
    mem_wr_reg_d     = mem_wr_reg_q;
    state_d          = state_q;
    cnt_d            = cnt_q;
    mcand_d          = mcand_q;
    mplier_d         = mplier_q;
    acc_d            = acc_q;
    mul_wr_reg_d     = mul_wr_reg_q;
    mul_wr_en_d      = mul_wr_en_q;
    stall            = 1'b0;
    // Multiplicand shifts left and multiplier shifts right each iteration,
    // so only bit 0 of the multiplier is ever inspected.
    mul_sum          = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_mul) begin
            stall        = 1'b1;
            mcand_d      = op1;
            mplier_d     = op2;
            acc_d        = '0;
            cnt_d        = '0;
            mul_wr_reg_d = wr_reg_i;
            mul_wr_en_d  = reg_wr_en_i;
            state_d      = BUSY;
          end else begin
            mem_valid_d      = valid_i;
            mem_alu_result_d = alu_res;
            mem_reg_a_data_d = reg_a_data_i;
            mem_wr_reg_d     = wr_reg_i;
            mem_is_load_d    = is_load_i;
            mem_is_store_d   = is_store_i;
            mem_reg_wr_en_d  = reg_wr_en_i;
          end
        end
        BUSY: begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_LAST) begin
            // Last iteration's sum goes straight to the output register.
            mem_valid_d      = 1'b1;
            mem_alu_result_d = mul_sum;
            mem_reg_a_data_d = reg_a_data_i;
            mem_wr_reg_d     = mul_wr_reg_q;
            mem_reg_wr_en_d  = mul_wr_en_q;
            mem_is_load_d    = 1'b0;
            mem_is_store_d   = 1'b0;
            cnt_d            = '0;
            state_d          = IDLE;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + SHW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      mul_wr_reg_q <= '0;
      mul_wr_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      mul_wr_reg_q <= mul_wr_reg_d;
      mul_wr_en_q  <= mul_wr_en_d;
    end
  end

  assign stall_o      = rst_i & stall;
  assign illegal_op_o = 1'b0;
`else
  logic illegal_q, illegal_d;

  always_comb begin
    mem_valid_d      = 1'b0;
    mem_is_load_d    = mem_is_load_q;
    mem_is_store_d   = mem_is_store_q;
    mem_reg_wr_en_d  = mem_reg_wr_en_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_reg_a_data_d = mem_reg_a_data_q;
    mem_wr_reg_d     = mem_wr_reg_q;
    illegal_d        = 1'b0;
    if (!flush_i) begin
      mem_valid_d      = valid_i;
      mem_alu_result_d = alu_res;
      mem_reg_a_data_d = reg_a_data_i;
      mem_wr_reg_d     = wr_reg_i;
      mem_is_load_d    = is_load_i;
      mem_is_store_d   = is_store_i;
      mem_reg_wr_en_d  = reg_wr_en_i;
      if (is_mul) begin
        mem_alu_result_d = '0;
        mem_reg_wr_en_d  = 1'b0;
        illegal_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign stall_o      = 1'b0;
  assign illegal_op_o = illegal_q;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_valid_q      <= 1'b0;
      mem_is_load_q    <= 1'b0;
      mem_is_store_q   <= 1'b0;
      mem_reg_wr_en_q  <= 1'b0;
      mem_alu_result_q <= '0;
      mem_reg_a_data_q <= '0;
      mem_wr_reg_q     <= '0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_is_load_q    <= mem_is_load_d;
      mem_is_store_q   <= mem_is_store_d;
      mem_reg_wr_en_q  <= mem_reg_wr_en_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_reg_a_data_q <= mem_reg_a_data_d;
      mem_wr_reg_q     <= mem_wr_reg_d;
    end
  end

  assign mem_valid_o      = mem_valid_q;
  assign mem_is_load_o    = mem_is_load_q;
  assign mem_is_store_o   = mem_is_store_q;
  assign mem_reg_wr_en_o  = mem_reg_wr_en_q;
  assign mem_alu_result_o = mem_alu_result_q;
  assign mem_reg_a_data_o = mem_reg_a_data_q;
  assign mem_wr_reg_o     = mem_wr_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage (32-bit datapath, 5-bit register index).
// Exercises the multiplier tests when EX_MUL_EN is defined, otherwise the
// illegal-MUL behaviour.
module tb_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  alu_op_i = '0;
  logic        use_imm_i = 1'b0;
  logic [31:0] reg_a_data_i = '0;
  logic [31:0] reg_b_data_i = '0;
  logic [31:0] imm_i = '0;
  logic [4:0]  wr_reg_i = '0;
  logic        is_load_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic        reg_wr_en_i = 1'b0;
  logic        stall_o;
  logic        mem_valid_o, mem_is_load_o, mem_is_store_o, mem_reg_wr_en_o;
  logic [31:0] mem_alu_result_o, mem_reg_a_data_o;
  logic [4:0]  mem_wr_reg_o;
  logic        illegal_op_o;

  int checks = 0;
  int errors = 0;

  ex_stage #(.DATA_WIDTH(32), .REGISTER_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .alu_op_i(alu_op_i), .use_imm_i(use_imm_i), .reg_a_data_i(reg_a_data_i),
    .reg_b_data_i(reg_b_data_i), .imm_i(imm_i), .wr_reg_i(wr_reg_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .reg_wr_en_i(reg_wr_en_i),
    .stall_o(stall_o), .mem_valid_o(mem_valid_o), .mem_is_load_o(mem_is_load_o),
    .mem_is_store_o(mem_is_store_o), .mem_reg_wr_en_o(mem_reg_wr_en_o),
    .mem_alu_result_o(mem_alu_result_o), .mem_reg_a_data_o(mem_reg_a_data_o),
    .mem_wr_reg_o(mem_wr_reg_o), .illegal_op_o(illegal_op_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic v, input logic [2:0] op, input logic ui,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] wr, input logic ld, input logic st, input logic we);
    valid_i = v; alu_op_i = op; use_imm_i = ui; reg_a_data_i = a; reg_b_data_i = b;
    imm_i = im; wr_reg_i = wr; is_load_i = ld; is_store_i = st; reg_wr_en_i = we;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(1, 3'd7, 0, 32'd5, 32'd3, 32'd0, 5'd1, 1, 1, 1);
    tick(); #1;
    checks++;
    if ({mem_valid_o, mem_is_load_o, mem_is_store_o, mem_reg_wr_en_o, illegal_op_o, stall_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, want 000000",
        {mem_valid_o, mem_is_load_o, mem_is_store_o, mem_reg_wr_en_o, illegal_op_o, stall_o});
    end
    checks++;
    if ({mem_alu_result_o, mem_reg_a_data_o, mem_wr_reg_o} !== 69'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h, want 0", mem_alu_result_o, mem_reg_a_data_o, mem_wr_reg_o);
    end
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive(1, 3'd0, 0, 32'd2, 32'hFFFF_FFFF, 32'd0, 5'd7, 0, 0, 1);
    tick();
    checks++;
    if (mem_alu_result_o !== 32'h0000_0001 || mem_valid_o !== 1'b1) begin
      errors++; $display("FAIL add_wrap: got res=%h valid=%b, want 00000001 1", mem_alu_result_o, mem_valid_o);
    end
    checks++;
    if (mem_wr_reg_o !== 5'd7 || mem_reg_wr_en_o !== 1'b1 || mem_is_store_o !== 1'b0) begin
      errors++; $display("FAIL add_ctrl: got wr=%0d we=%b st=%b, want 7 1 0", mem_wr_reg_o, mem_reg_wr_en_o, mem_is_store_o);
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  ops [5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [31:0] as  [5]  = '{32'd7, 32'h0FF0_F0F0, 32'h0FF0_F0F0, 32'h0FF0_F0F0, 32'd0};
    logic [31:0] bs  [5]  = '{32'd5, 32'hF0F0_FF00, 32'hF0F0_FF00, 32'hF0F0_FF00, 32'd3};
    logic [31:0] ims [5]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE};
    logic        uis [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp [5]  = '{32'hFFFF_FFFE, 32'h00F0_F000, 32'hFFF0_FFF0, 32'hFF00_0FF0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      drive(1, ops[i], uis[i], as[i], bs[i], ims[i], 5'd3, 0, 0, 1);
      tick();
      checks++;
      if (mem_alu_result_o !== exp[i] || mem_valid_o !== 1'b1) begin
        errors++; $display("FAIL alu_op%0d: got res=%h valid=%b, want %h 1", ops[i], mem_alu_result_o, mem_valid_o, exp[i]);
      end
    end
  endtask

  task automatic test_slt_sll();
    drive(1, 3'd5, 1, 32'd0, 32'hFFFF_FFFE, 32'd3, 5'd4, 0, 0, 1);
    tick();
    checks++;
    if (mem_alu_result_o !== 32'd1) begin
      errors++; $display("FAIL slt_signed: got %h, want 00000001", mem_alu_result_o);
    end
    drive(1, 3'd6, 1, 32'd0, 32'd1, 32'd35, 5'd4, 0, 0, 1);
    tick();
    checks++;
    if (mem_alu_result_o !== 32'h0000_0008) begin
      errors++; $display("FAIL sll_mask: got %h, want 00000008", mem_alu_result_o);
    end
  endtask

  task automatic test_store();
    drive(1, 3'd0, 1, 32'h0000_DEAD, 32'h100, 32'h10, 5'd0, 0, 1, 0);
    tick();
    checks++;
    if (mem_alu_result_o !== 32'h110 || mem_reg_a_data_o !== 32'h0000_DEAD ||
        mem_is_store_o !== 1'b1 || mem_is_load_o !== 1'b0 || mem_reg_wr_en_o !== 1'b0) begin
      errors++; $display("FAIL store: got res=%h data=%h st=%b ld=%b we=%b, want 110 DEAD 1 0 0",
        mem_alu_result_o, mem_reg_a_data_o, mem_is_store_o, mem_is_load_o, mem_reg_wr_en_o);
    end
    drive(1, 3'd0, 1, 32'd0, 32'h200, 32'h4, 5'd12, 1, 0, 1);
    tick();
    checks++;
    if (mem_alu_result_o !== 32'h204 || mem_is_load_o !== 1'b1 || mem_wr_reg_o !== 5'd12) begin
      errors++; $display("FAIL load: got res=%h ld=%b wr=%0d, want 204 1 12", mem_alu_result_o, mem_is_load_o, mem_wr_reg_o);
    end
  endtask

  task automatic test_idle_flush();
    drive(0, 3'd0, 0, 32'd1, 32'd1, 32'd0, 5'd1, 0, 0, 1);
    tick();
    checks++;
    if (mem_valid_o !== 1'b0) begin
      errors++; $display("FAIL idle_valid: got %b, want 0", mem_valid_o);
    end
    drive(1, 3'd0, 0, 32'd1, 32'd1, 32'd0, 5'd1, 0, 0, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (mem_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_single: got valid=%b, want 0", mem_valid_o);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 3'd0, 0, 32'd10, 32'd20, 32'd0, 5'd9, 0, 0, 1);
    tick();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (mem_valid_o !== 1'b0 || mem_alu_result_o !== 32'd0 || mem_wr_reg_o !== 5'd0 || mem_reg_wr_en_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: got valid=%b res=%h wr=%0d we=%b, want 0 0 0 0",
        mem_valid_o, mem_alu_result_o, mem_wr_reg_o, mem_reg_wr_en_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int unsigned stalls = 0;
    int unsigned edges = 0;
    bit done = 0;
    drive(1, 3'd7, 0, 32'h0000_0005, 32'h0001_0003, 32'd0, 5'd9, 0, 0, 1);
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stall_o) stalls++;
      tick();
      edges++;
      if (mem_valid_o) done = 1;
    end
    checks++;
    if (!done || edges != 33 || stalls != 32) begin
      errors++; $display("FAIL mul_timing: got done=%0d edges=%0d stalls=%0d, want 1 33 32", done, edges, stalls);
    end
    checks++;
    if (mem_alu_result_o !== 32'h0005_000F || mem_wr_reg_o !== 5'd9 || mem_reg_wr_en_o !== 1'b1) begin
      errors++; $display("FAIL mul_result: got res=%h wr=%0d we=%b, want 0005000F 9 1", mem_alu_result_o, mem_wr_reg_o, mem_reg_wr_en_o);
    end
    drive(1, 3'd0, 0, 32'd4, 32'd6, 32'd0, 5'd2, 0, 0, 1);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL mul_next_stall: got %b, want 0", stall_o);
    end
    tick();
    checks++;
    if (mem_alu_result_o !== 32'd10 || mem_valid_o !== 1'b1) begin
      errors++; $display("FAIL mul_next_add: got res=%h valid=%b, want 0000000a 1", mem_alu_result_o, mem_valid_o);
    end
  endtask

  task automatic test_mul_flush();
    int unsigned seen = 0;
    drive(1, 3'd7, 0, 32'd3, 32'd7, 32'd0, 5'd5, 0, 0, 1);
    tick();
    repeat (10) tick();
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL mulflush_busy: got stall=%b, want 1", stall_o);
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL mulflush_stall: got stall=%b, want 0", stall_o);
    end
    tick();
    flush_i = 1'b0;
    drive(1, 3'd0, 0, 32'd3, 32'd4, 32'd0, 5'd6, 0, 0, 1);
    tick();
    checks++;
    if (mem_alu_result_o !== 32'd7 || mem_valid_o !== 1'b1 || mem_wr_reg_o !== 5'd6) begin
      errors++; $display("FAIL mulflush_add: got res=%h valid=%b wr=%0d, want 7 1 6", mem_alu_result_o, mem_valid_o, mem_wr_reg_o);
    end
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_valid_o || stall_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mulflush_ghost: got %0d active cycles, want 0", seen);
    end
  endtask

  task automatic test_mul_reset();
    int unsigned seen = 0;
    drive(1, 3'd0, 0, 32'd1, 32'd2, 32'd0, 5'd8, 0, 0, 1);
    tick();
    drive(1, 3'd7, 0, 32'd9, 32'd9, 32'd0, 5'd8, 0, 0, 1);
    tick();
    repeat (5) tick();
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({mem_valid_o, mem_reg_wr_en_o, stall_o, illegal_op_o} !== 4'b0 ||
        mem_alu_result_o !== 32'd0 || mem_wr_reg_o !== 5'd0) begin
      errors++; $display("FAIL mulreset_outputs: got valid=%b we=%b stall=%b res=%h wr=%0d, want all 0",
        mem_valid_o, mem_reg_wr_en_o, stall_o, mem_alu_result_o, mem_wr_reg_o);
    end
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_valid_o || stall_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mulreset_ghost: got %0d active cycles, want 0", seen);
    end
  endtask
`else
  task automatic test_mul_illegal();
    drive(1, 3'd7, 0, 32'd5, 32'h0001_0003, 32'd0, 5'd9, 0, 0, 1);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL illegal_stall: got %b, want 0", stall_o);
    end
    tick();
    checks++;
    if (mem_valid_o !== 1'b1 || mem_alu_result_o !== 32'd0 || mem_reg_wr_en_o !== 1'b0 || illegal_op_o !== 1'b1) begin
      errors++; $display("FAIL illegal_mul: got valid=%b res=%h we=%b ill=%b, want 1 0 0 1",
        mem_valid_o, mem_alu_result_o, mem_reg_wr_en_o, illegal_op_o);
    end
    drive(1, 3'd0, 0, 32'd1, 32'd1, 32'd0, 5'd2, 0, 0, 1);
    tick();
    checks++;
    if (illegal_op_o !== 1'b0 || mem_alu_result_o !== 32'd2 || mem_reg_wr_en_o !== 1'b1) begin
      errors++; $display("FAIL illegal_pulse: got ill=%b res=%h we=%b, want 0 2 1", illegal_op_o, mem_alu_result_o, mem_reg_wr_en_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_slt_sll();
    test_store();
    test_idle_flush();
    test_async_reset();
`ifdef EX_MUL_EN
    test_mul();
    test_mul_flush();
    test_mul_reset();
`else
    test_mul_illegal();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
